pll_reset_sequencer: RTL and testbench

- Control-side partner of the PLL wrapper.
- Drives the PLL's active-high reset input and watches its lock output.
- Qualifies lock and sequences the system reset released to the 64/16 MHz core.
- Runs on the 50 MHz reference clock. Retries PLL reset on lock timeout, and re-sequences on lock loss or software request.

---
 rtl/pll_reset_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock-qualification sequencer; releases the core reset once lock is proven stable.
// Define PLL_LOCK_FAULT_EN to latch a FAULT state after MAX_RETRIES lock timeouts.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int SYNC_STAGES         = 2,
    parameter int MAX_RETRIES         = 8
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic       fault
);

    localparam int MAX_CNT =
        (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES)
            ? ((LOCK_TIMEOUT_CYCLES > PLL_RST_CYCLES) ? LOCK_TIMEOUT_CYCLES : PLL_RST_CYCLES)
            : ((LOCK_STABLE_CYCLES  > PLL_RST_CYCLES) ? LOCK_STABLE_CYCLES  : PLL_RST_CYCLES);
    localparam int CNT_W = $clog2(MAX_CNT);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       RST_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t       STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t       TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0] RETRY_LIMIT  = 8'(MAX_RETRIES);

`ifdef PLL_LOCK_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_e;

    // Reset synchroniser: assertion is immediate, release waits two refclk edges.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   lk;

    always_ff @(posedge refclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk = lock_sync_q[SYNC_STAGES-1];

    state_e     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] retry_q, retry_d, retry_inc;
    logic       pll_rst_q, pll_rst_d;
    logic       sys_reset_q, sys_reset_d;
    logic       ready_q, ready_d;

    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    if (FAULT_EN && (retry_inc == RETRY_LIMIT)) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_PLL_RST;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_STABLE: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            // Lock loss and soft reset share one exit, so a coincident pair costs a single pulse.
            ST_RUN: begin
                if (!lk || soft_reset) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            end

`ifdef PLL_LOCK_FAULT_EN
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
`endif

            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d   = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        sys_reset_d = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge refclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
        end
    end

`ifdef PLL_LOCK_FAULT_EN
    logic fault_q;

    always_ff @(posedge refclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign pll_rst     = pll_rst_q;
    assign sys_reset   = sys_reset_q;
    assign ready       = ready_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with randomised timing, plus a per-cycle reference model.
module tb_pll_reset_sequencer;

    localparam int P_RST          = 4;
    localparam int P_STAB         = 8;
    localparam int P_TO           = 32;
    localparam int P_SYNC         = 2;
    localparam int RST_SYNC_DEPTH = 2;
`ifdef PLL_LOCK_FAULT_EN
    localparam int P_MAXR   = 3;
    localparam bit FAULT_EN = 1'b1;
`else
    localparam int P_MAXR   = 8;
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       refclk     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] retry_count;
    logic       fault;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (P_RST),
        .LOCK_STABLE_CYCLES (P_STAB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .SYNC_STAGES        (P_SYNC),
        .MAX_RETRIES        (P_MAXR)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .soft_reset (soft_reset),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .retry_count(retry_count),
        .fault      (fault)
    );

    always #10 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, expv);
        end
    endtask

    // Reference model: phase plus dwell time in that phase, lock seen through a delay line.
    typedef enum int {PH_PLL_RST, PH_WAIT_LOCK, PH_STABLE, PH_RUN, PH_FAULT} phase_e;

    phase_e m_phase   = PH_PLL_RST;
    int     m_dwell   = 0;
    int     m_retries = 0;
    int     m_age     = 0;
    bit     m_lk_pipe[$];

    task automatic go(input phase_e p);
        m_phase = p;
        m_dwell = 0;
    endtask

    task automatic model_step();
        bit lk;
        if (!rst_n) begin
            m_phase   = PH_PLL_RST;
            m_dwell   = 0;
            m_retries = 0;
            m_age     = 0;
            m_lk_pipe.delete();
            repeat (P_SYNC) m_lk_pipe.push_back(1'b0);
        end else if (m_age < RST_SYNC_DEPTH) begin
            m_age++;
        end else begin
            lk = m_lk_pipe.pop_front();
            m_lk_pipe.push_back(pll_locked);
            case (m_phase)
                PH_PLL_RST: begin
                    m_dwell++;
                    if (m_dwell == P_RST) go(PH_WAIT_LOCK);
                end
                PH_WAIT_LOCK: begin
                    if (lk) go(PH_STABLE);
                    else begin
                        m_dwell++;
                        if (m_dwell == P_TO) begin
                            if (m_retries < 255) m_retries++;
                            if (FAULT_EN && m_retries == P_MAXR) go(PH_FAULT);
                            else go(PH_PLL_RST);
                        end
                    end
                end
                PH_STABLE: begin
                    if (!lk) go(PH_WAIT_LOCK);
                    else begin
                        m_dwell++;
                        if (m_dwell == P_STAB) go(PH_RUN);
                    end
                end
                PH_RUN: begin
                    if (!lk || soft_reset) go(PH_PLL_RST);
                end
                default: ;
            endcase
        end
    endtask

    always begin
        @(posedge refclk);
        #2;
        model_step();
        check("cyc_pll_rst",     pll_rst,     m_phase inside {PH_PLL_RST, PH_FAULT});
        check("cyc_sys_reset",   sys_reset,   m_phase != PH_RUN);
        check("cyc_ready",       ready,       m_phase == PH_RUN);
        check("cyc_retry_count", retry_count, m_retries);
        check("cyc_fault",       fault,       m_phase == PH_FAULT);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_reset;
            default: return ready;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input logic val, input int budget);
        int n = 0;
        while (sig(sel) !== val && n < budget) begin
            @(negedge refclk);
            n++;
        end
        if (sig(sel) !== val) check(tag, sig(sel), val);
    endtask

    task automatic rst_width(output int w);
        w = 0;
        while (pll_rst === 1'b1 && w < 200) begin
            @(negedge refclk);
            w++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int t;
        int w;

        tick(3);
        check("reset_pll_rst",   pll_rst,     1);
        check("reset_sys_reset", sys_reset,   1);
        check("reset_ready",     ready,       0);
        check("reset_retry",     retry_count, 0);
        check("reset_fault",     fault,       0);
        rst_n = 1'b1;

        // Power-up lock after the first PLL reset pulse has finished.
        tick(8 + int'($urandom_range(0, 6)));
        pll_locked = 1'b1;
        t = cyc + 1;
        wait_sig("powerup_wait_release", 1, 1'b0, 60);
        check("powerup_release_latency", cyc - t, P_SYNC + P_STAB);
        check("powerup_ready", ready, 1);
        check("powerup_retry", retry_count, 0);

        // Lock loss in RUN.
        tick(int'($urandom_range(1, 20)));
        pll_locked = 1'b0;
        t = cyc + 1;
        wait_sig("lockloss_wait_reset", 1, 1'b1, 20);
        check("lockloss_latency",  cyc - t, P_SYNC);
        check("lockloss_ready",    ready,   0);
        check("lockloss_pll_rst",  pll_rst, 1);
        rst_width(w);
        check("lockloss_pulse_width", w, P_RST);

        // Lock chatter: drop after 5 cycles in STABLE, then relock for good.
        pll_locked = 1'b1;
        tick(7);
        pll_locked = 1'b0;
        tick(int'($urandom_range(2, 8)));
        check("chatter_holds_reset", sys_reset, 1);
        pll_locked = 1'b1;
        t = cyc + 1;
        wait_sig("chatter_wait_release", 1, 1'b0, 60);
        check("chatter_release_latency", cyc - t, P_SYNC + P_STAB);
        check("chatter_retry", retry_count, 0);

        // Soft reset in RUN.
        tick(int'($urandom_range(1, 10)));
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("soft_pll_rst",   pll_rst,   1);
        check("soft_sys_reset", sys_reset, 1);
        check("soft_ready",     ready,     0);
        rst_width(w);
        check("soft_pulse_width", w, P_RST);
        wait_sig("soft_wait_release", 1, 1'b0, 40);
        check("soft_ready_again", ready, 1);

        // Soft reset coinciding with synchronised lock loss.
        tick(int'($urandom_range(1, 10)));
        pll_locked = 1'b0;
        tick(2);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("both_pll_rst", pll_rst, 1);
        rst_width(w);
        check("both_pulse_width", w, P_RST);
        pll_locked = 1'b1;
        tick(P_SYNC + 1);
        check("both_single_pulse", pll_rst, 0);
        wait_sig("both_wait_release", 1, 1'b0, 40);
        check("both_retry", retry_count, 0);

        // Soft reset in WAIT_LOCK is ignored.
        tick(int'($urandom_range(1, 10)));
        pll_locked = 1'b0;
        wait_sig("wait_lockloss", 0, 1'b1, 20);
        rst_width(w);
        tick(3);
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        check("soft_in_wait_pll_rst",   pll_rst,   0);
        check("soft_in_wait_sys_reset", sys_reset, 1);

        // Lock timeouts with pll_locked held low.
        wait_sig("timeout1_wait", 0, 1'b1, 60);
        t = cyc;
        check("timeout1_retry", retry_count, 1);
        rst_width(w);
        check("timeout_pulse_width", w, P_RST);
        wait_sig("timeout2_wait", 0, 1'b1, 60);
        check("timeout_period", cyc - t, P_RST + P_TO);
        check("timeout2_retry", retry_count, 2);
        rst_width(w);
`ifdef PLL_LOCK_FAULT_EN
        wait_sig("fault_wait", 0, 1'b1, 60);
        check("fault_flag",  fault,       1);
        check("fault_retry", retry_count, P_MAXR);
        pll_locked = 1'b1;
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        tick(60);
        check("fault_sticky_flag",    fault,     1);
        check("fault_sticky_pll_rst", pll_rst,   1);
        check("fault_sticky_sys",     sys_reset, 1);
        rst_n = 1'b0;
        #1;
        check("fault_cleared", fault, 0);
        tick(1);
        rst_n = 1'b1;
        wait_sig("fault_restart_release", 1, 1'b0, 80);
        check("fault_restart_ready", ready, 1);
`else
        wait_sig("timeout3_wait", 0, 1'b1, 60);
        check("timeout3_retry", retry_count, 3);
        begin
            int n = 0;
            while (retry_count !== 8'd255 && n < 300 * (P_RST + P_TO)) begin
                tick(1);
                n++;
            end
        end
        check("retry_saturates", retry_count, 255);
        tick(2 * (P_RST + P_TO) + 1);
        check("retry_stays_saturated", retry_count, 255);
        pll_locked = 1'b1;
        wait_sig("sat_wait_release", 1, 1'b0, 80);
`endif

        // Asynchronous reset while in RUN.
        tick(int'($urandom_range(1, 10)));
        rst_n = 1'b0;
        #1;
        check("async_pll_rst",   pll_rst,     1);
        check("async_sys_reset", sys_reset,   1);
        check("async_ready",     ready,       0);
        check("async_retry",     retry_count, 0);
        check("async_fault",     fault,       0);
        tick(2);
        rst_n = 1'b1;

        // Random soak against the reference model.
        for (int seg = 0; seg < 60; seg++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 40)) begin
                soft_reset = ($urandom_range(0, 15) == 0);
                tick(1);
            end
            soft_reset = 1'b0;
        end

        pll_locked = 1'b1;
        wait_sig("final_wait_release", 1, 1'b0, 120);
        check("final_ready", ready, 1);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
